alu_seq: RTL and testbench

Parametrised, clocked successor to the 1-bit `sum_alu`.
- Performs WIDTH-bit add, subtract, logic, accumulate, clear and multi-cycle multiply on a start/done handshake.
- Registers its result and carry/zero flags.
- Sits between the datapath operand registers and the writeback stage; software-visible behaviour is defined only by the handshake below.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_mul_unit.sv | 44 ++++
 rtl/alu_seq.sv | 95 +++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for alu_seq, its decoder and the testbench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_ACC = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Start/done handshake bundle between the operand stage and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, out, carry, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, out, carry, zero
    );
endinterface

// File: rtl/alu_mul_unit.sv
// Shift-add multiplier: one bit of b per enabled cycle, LSB first.
module alu_mul_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // product already includes the current step so the FSM can write back on the last edge
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (en) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked WIDTH-bit ALU: single-cycle ops plus an iterative multiply on a start/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             zero_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH:0]     res;
    logic               mul_load;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_load = (state == S_IDLE) && bus.start && (bus.op == OP_MUL);

    alu_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .en      (state == S_MUL),
        .a       (bus.a),
        .b       (bus.b),
        .last    (mul_last),
        .product (mul_prod)
    );

    // bit WIDTH carries the add carry-out / subtract borrow; zero for logic ops
    always_comb begin
        res = '0;
        case (bus.op)
            OP_ADD:  res = {1'b0, bus.a} + {1'b0, bus.b};
            OP_SUB:  res = {1'b0, bus.a} - {1'b0, bus.b};
            OP_AND:  res = {1'b0, bus.a & bus.b};
            OP_OR:   res = {1'b0, bus.a | bus.b};
            OP_XOR:  res = {1'b0, bus.a ^ bus.b};
            OP_ACC:  res = {1'b0, out_q} + {1'b0, bus.a};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state  <= S_MUL;
                            busy_q <= 1'b1;
                        end else begin
                            out_q   <= res[WIDTH-1:0];
                            carry_q <= res[WIDTH];
                            zero_q  <= (res[WIDTH-1:0] == '0);
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        out_q   <= mul_prod[WIDTH-1:0];
                        carry_q <= |mul_prod[2*WIDTH-1:WIDTH];
                        zero_q  <= (mul_prod[WIDTH-1:0] == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.carry = carry_q;
    assign bus.zero  = zero_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a monitor pops on done.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        logic         zero;
    } exp_t;

    exp_t sb[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 with out=0x%0h, expected no completion", bus.out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_out",   32'(bus.out),   32'(e.out));
                chk("sb_carry", 32'(bus.carry), 32'(e.carry));
                chk("sb_zero",  32'(bus.zero),  32'(e.zero));
            end
        end
    end

    task automatic expect_res(input logic [W-1:0] o, input logic c, input logic z);
        exp_t e;
        e.out = o; e.carry = c; e.zero = z;
        sb.push_back(e);
    endtask

    // Present a request for the cycle that starts at this negedge
    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(bus.out),   0);
        chk("rst_carry", 32'(bus.carry), 0);
        chk("rst_zero",  32'(bus.zero),  0);
        chk("rst_done",  32'(bus.done),  0);
        chk("rst_busy",  32'(bus.busy),  0);
        rst = 1'b0;

        // ADD 200+100 = 300 -> 44 with carry; done is a single-cycle pulse
        expect_res(8'd44, 1'b1, 1'b0);
        drive(OP_ADD, 8'd200, 8'd100);
        idle();
        chk("add_done_hi", 32'(bus.done), 1);
        @(negedge clk);
        chk("add_done_lo", 32'(bus.done), 0);

        expect_res(8'd0, 1'b0, 1'b1);
        drive(OP_SUB, 8'd5, 8'd5);
        expect_res(8'd252, 1'b1, 1'b0);
        drive(OP_SUB, 8'd3, 8'd7);
        idle();

        // MUL 13*11 = 143: busy for W cycles, done the cycle after
        expect_res(8'd143, 1'b0, 1'b0);
        drive(OP_MUL, 8'd13, 8'd11);
        idle();
        for (int i = 1; i <= W; i++) begin
            chk("mul_busy", 32'(bus.busy), 1);
            chk("mul_nodone", 32'(bus.done), 0);
            if (i < W) @(negedge clk);
        end
        @(negedge clk);
        chk("mul_busy_end", 32'(bus.busy), 0);
        chk("mul_done", 32'(bus.done), 1);

        // 16*16 = 256: low byte zero, overflow flagged
        expect_res(8'd0, 1'b1, 1'b1);
        drive(OP_MUL, 8'd16, 8'd16);
        idle();
        repeat (W + 1) @(negedge clk);

        // CLR then three back-to-back ACCs
        expect_res(8'd0, 1'b0, 1'b1);
        drive(OP_CLR, 8'd0, 8'd0);
        expect_res(8'd100, 1'b0, 1'b0);
        drive(OP_ACC, 8'd100, 8'd0);
        expect_res(8'd200, 1'b0, 1'b0);
        drive(OP_ACC, 8'd100, 8'd0);
        chk("acc_done_1", 32'(bus.done), 1);
        expect_res(8'd44, 1'b1, 1'b0);
        drive(OP_ACC, 8'd100, 8'd0);
        chk("acc_done_2", 32'(bus.done), 1);
        idle();
        chk("acc_done_3", 32'(bus.done), 1);
        @(negedge clk);

        // ADD issued mid-multiply must be dropped and not resample operands
        expect_res(8'd63, 1'b0, 1'b0);
        drive(OP_MUL, 8'd7, 8'd9);
        idle();
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        idle();
        repeat (W - 3) @(negedge clk);
        chk("mid_done", 32'(bus.done), 1);
        @(negedge clk);
        chk("mid_no_extra", 32'(bus.done), 0);

        // Reset in the 4th multiply cycle aborts silently
        drive(OP_MUL, 8'd5, 8'd6);
        idle();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out",   32'(bus.out),   0);
        chk("abort_carry", 32'(bus.carry), 0);
        chk("abort_zero",  32'(bus.zero),  0);
        chk("abort_done",  32'(bus.done),  0);
        chk("abort_busy0", 32'(bus.busy),  0);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);

        // XOR then idle: result must hold, no done
        expect_res(8'h55, 1'b0, 1'b0);
        drive(OP_XOR, 8'hAA, 8'hFF);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_out",  32'(bus.out),  32'h55);
            chk("idle_done", 32'(bus.done), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
